imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares the single-port, 256x32, synchronous-read RAM between the pipeline's instruction-fetch port (IF) and data-memory port (DM, load/store).
- Picks one requester per cycle and drives the RAM request, write enable, word address, byte mask and write data.
- Returns read data one cycle later to the requester that issued it.
- Sits between the pipelined core and the RAM. It does not instantiate the RAM.

Parameters:
- ADDR_W, 8, RAM word-address width. Word address = byte_addr[ADDR_W+1:2].
- STARVE_LIMIT, 4, max consecutive cycles IF may be denied while requesting before it is force-granted; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- if_req  input  1  fetch request (read only)
- if_addr  input  32  fetch byte address
- if_gnt  output  1  fetch granted this cycle
- if_rvalid  output  1  if_rdata valid (one cycle after if_gnt)
- if_rdata  output  32  fetched instruction word
- dm_req  input  1  data request
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  32  data byte address
- dm_be  input  4  store byte enables
- dm_wdata  input  32  store data
- dm_gnt  output  1  data granted this cycle
- dm_rvalid  output  1  dm_rdata valid (one cycle after a load grant)
- dm_rdata  output  32  load word
- mem_request  output  1  to RAM request
- mem_w_en  output  1  to RAM w_en
- mem_address  output  ADDR_W  to RAM address
- mem_masking  output  4  to RAM masking
- mem_write_data  output  32  to RAM write_data
- mem_read_data  input  32  from RAM read_data (registered in RAM)

Behaviour:
- Grant is combinational from req and registered state. At most one of if_gnt/dm_gnt is high. gnt implies mem_request=1 in the same cycle.
- A requester holds req and its address/data stable until it sees gnt. The grant cycle consumes the request.
- Only one requester active: it wins.
- Both requesting (conflict): DM wins, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
- starve_cnt (4-bit):
  - increments when if_req && !if_gnt;
  - clears when if_gnt or !if_req;
  - saturates at STARVE_LIMIT.
- Muxing: mem_w_en = dm_gnt & dm_we. mem_masking = dm_be on DM grant, 4'b0000 on IF grant. mem_address = granted addr[ADDR_W+1:2]; addr[1:0] and upper bits are ignored, so addresses wrap modulo 4*2^ADDR_W bytes. mem_write_data = dm_wdata.
- No grant: mem_request=0, mem_w_en=0, mem_masking=0, other mem outputs don't-care (drive 0).
- Read return:
  - Registers rd_owner_if = if_gnt and rd_pend = (if_gnt | dm_gnt & !dm_we).
  - Next cycle: if_rvalid = rd_pend & rd_owner_if; dm_rvalid = rd_pend & !rd_owner_if.
  - if_rdata and dm_rdata are both wired to mem_read_data. Consumers qualify with rvalid.
- Stores give no rvalid.
- Back-to-back grants to alternating owners are legal every cycle. Throughput is 1 access/cycle.
- Reset (async, mid-operation included):
  - starve_cnt=0, rd_pend=0, rd_owner_if=0, so both rvalid=0 immediately.
  - While rst=1, both gnt=0 and mem_request=0.
  - A read issued in the cycle rst asserts is dropped, and the requester must re-request.
- Simultaneous dm_req with dm_we=1 and a forced IF grant: the store waits. No partial write occurs.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: conflicts resolve round-robin. A registered last_was_if bit picks the other requester than the previous conflict winner; reset value 0, so the first conflict goes to IF. starve_cnt and STARVE_LIMIT are unused and their logic is removed.
- Undefined: DM-priority with the starvation override as above.

Decomposition:
- Package rv_mem_pkg holds:
  - WORD_W=32, BE_W=4;
  - localparam OWN_IF=1'b1, OWN_DM=1'b0;
  - a function byte_to_word(addr) returning addr[ADDR_W+1:2].
- Sub-module arb_pick: combinational winner select from if_req, dm_req, starve_hit (or last_was_if). It keeps the policy swappable under ARB_RR_EN.
- Counters, the read-return pipe and muxing stay in the top.

Test Plan:
- Load return, no contention:
  - stimulus: dm_req=1, dm_we=0, dm_addr=0x0000_0010 for 1 cycle;
  - response: dm_gnt=1, mem_address=8'h04, mem_w_en=0;
  - next cycle: dm_rvalid=1, dm_rdata=mem[4].
- Store with masks:
  - stimulus: dm_we=1, dm_addr=0x20, dm_be=4'b0011, dm_wdata=0xAABB_CCDD;
  - response: mem_address=8'h08, mem_masking=4'b0011, mem_w_en=1, no dm_rvalid;
  - read back of word 8: low half 0xCCDD, upper half unchanged.
- Starvation override:
  - stimulus: if_req and dm_req both held high continuously, STARVE_LIMIT=4;
  - response: dm_gnt for 4 cycles, if_gnt on the 5th, then pattern repeats;
  - if_rvalid asserts only the cycle after each if_gnt.
- Alternating reads:
  - stimulus: IF at 0x0 and DM load at 0x4 granted in consecutive cycles;
  - response: if_rvalid then dm_rvalid on consecutive cycles with mem[0], mem[1];
  - never both rvalid high together.
- Async reset mid-read:
  - stimulus: assert rst asynchronously in the cycle after if_gnt;
  - response: if_rvalid drops to 0 immediately, gnt=0 while rst=1;
  - after release, the first conflict follows the reset policy.
- Address wrap:
  - stimulus: if_addr=0x0000_0404;
  - response: mem_address=8'h01.
- ARB_RR_EN build:
  - stimulus: continuous conflict;
  - response: grants strictly alternate IF, DM, IF, ...

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared constants and address helpers for the IF/DM memory arbiter.
package rv_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic OWN_IF = 1'b1;
  localparam logic OWN_DM = 1'b0;

  // Byte address to word address; callers truncate to their RAM width.
  function automatic logic [WORD_W-3:0] byte_to_word(input logic [WORD_W-1:0] addr);
    return addr[WORD_W-1:2];
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select for the shared RAM port.
// Policy: DM priority with starvation override, or round-robin when ARB_RR_EN is defined.
module arb_pick (
  input  logic if_req_i,
  input  logic dm_req_i,
  input  logic prio_i,    // starve_hit, or last_was_if under ARB_RR_EN
  output logic if_win_o,
  output logic dm_win_o
);

  logic if_pref;

`ifdef ARB_RR_EN
  assign if_pref = ~prio_i;
`else
  assign if_pref = prio_i;
`endif

  always_comb begin
    if_win_o = if_req_i & (~dm_req_i | if_pref);
    dm_win_o = dm_req_i & ~if_win_o;
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates the single-port synchronous-read RAM between instruction fetch and data port.
// Optional macro ARB_RR_EN selects round-robin conflict resolution.
module imem_dmem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [WORD_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [WORD_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [WORD_W-1:0] dm_addr_i,
  input  logic [BE_W-1:0]   dm_be_i,
  input  logic [WORD_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_rvalid_o,
  output logic [WORD_W-1:0] dm_rdata_o,
  output logic              mem_request_o,
  output logic              mem_w_en_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [BE_W-1:0]   mem_masking_o,
  output logic [WORD_W-1:0] mem_write_data_o,
  input  logic [WORD_W-1:0] mem_read_data_i
);

  logic if_req_v, dm_req_v, prio;
  logic rd_pend_q, rd_pend_d;
  logic rd_owner_if_q, rd_owner_if_d;

  // No grant may be issued while reset is held.
  assign if_req_v = if_req_i & ~rst_i;
  assign dm_req_v = dm_req_i & ~rst_i;

  arb_pick u_pick (
    .if_req_i (if_req_v),
    .dm_req_i (dm_req_v),
    .prio_i   (prio),
    .if_win_o (if_gnt_o),
    .dm_win_o (dm_gnt_o)
  );

`ifdef ARB_RR_EN
  logic last_was_if_q, last_was_if_d;

  assign prio = last_was_if_q;

  always_comb begin
    last_was_if_d = last_was_if_q;
    if (if_req_v && dm_req_v) last_was_if_d = if_gnt_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_was_if_q <= 1'b0;
    else       last_was_if_q <= last_was_if_d;
  end
`else
  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  assign prio = (starve_q == Limit);

  always_comb begin
    starve_d = starve_q;
    if (!if_req_i || if_gnt_o)  starve_d = 4'd0;
    else if (starve_q != Limit) starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) starve_q <= 4'd0;
    else       starve_q <= starve_d;
  end
`endif

  always_comb begin
    rd_pend_d     = if_gnt_o | (dm_gnt_o & ~dm_we_i);
    rd_owner_if_d = if_gnt_o ? OWN_IF : OWN_DM;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_pend_q     <= 1'b0;
      rd_owner_if_q <= 1'b0;
    end else begin
      rd_pend_q     <= rd_pend_d;
      rd_owner_if_q <= rd_owner_if_d;
    end
  end

  always_comb begin
    mem_request_o    = 1'b0;
    mem_w_en_o       = 1'b0;
    mem_address_o    = '0;
    mem_masking_o    = '0;
    mem_write_data_o = '0;
    if (if_gnt_o) begin
      mem_request_o = 1'b1;
      mem_address_o = ADDR_W'(byte_to_word(if_addr_i));
    end else if (dm_gnt_o) begin
      mem_request_o    = 1'b1;
      mem_w_en_o       = dm_we_i;
      mem_address_o    = ADDR_W'(byte_to_word(dm_addr_i));
      mem_masking_o    = dm_be_i;
      mem_write_data_o = dm_wdata_i;
    end
  end

  always_comb begin
    if_rvalid_o = rd_pend_q & rd_owner_if_q;
    dm_rvalid_o = rd_pend_q & ~rd_owner_if_q;
    if_rdata_o  = mem_read_data_i;
    dm_rdata_o  = mem_read_data_i;
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter with a behavioural 256x32 synchronous-read RAM.
module tb_imem_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata;
  logic        mem_request, mem_w_en;
  logic [7:0]  mem_address;
  logic [3:0]  mem_masking;
  logic [31:0] mem_write_data, mem_read_data;

  int vec  = 0;
  int miss = 0;

  logic [31:0] ram [256];

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.ADDR_W(8), .STARVE_LIMIT(4)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .if_req_i         (if_req),
    .if_addr_i        (if_addr),
    .if_gnt_o         (if_gnt),
    .if_rvalid_o      (if_rvalid),
    .if_rdata_o       (if_rdata),
    .dm_req_i         (dm_req),
    .dm_we_i          (dm_we),
    .dm_addr_i        (dm_addr),
    .dm_be_i          (dm_be),
    .dm_wdata_i       (dm_wdata),
    .dm_gnt_o         (dm_gnt),
    .dm_rvalid_o      (dm_rvalid),
    .dm_rdata_o       (dm_rdata),
    .mem_request_o    (mem_request),
    .mem_w_en_o       (mem_w_en),
    .mem_address_o    (mem_address),
    .mem_masking_o    (mem_masking),
    .mem_write_data_o (mem_write_data),
    .mem_read_data_i  (mem_read_data)
  );

  always @(posedge clk) begin
    if (mem_request) begin
      if (mem_w_en) begin
        for (int b = 0; b < 4; b++)
          if (mem_masking[b]) ram[mem_address][8*b +: 8] <= mem_write_data[8*b +: 8];
      end else begin
        mem_read_data <= ram[mem_address];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_be = '0; dm_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h4; dm_addr = 32'h8;
    @(negedge clk);
    vec++; if (if_gnt !== 1'b0) begin miss++; $display("FAIL rst_if_gnt got %b want 0", if_gnt); end
    vec++; if (dm_gnt !== 1'b0) begin miss++; $display("FAIL rst_dm_gnt got %b want 0", dm_gnt); end
    vec++; if (mem_request !== 1'b0) begin miss++; $display("FAIL rst_mem_request got %b want 0", mem_request); end
    vec++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin miss++; $display("FAIL rst_rvalid got %b want 00", {if_rvalid, dm_rvalid}); end
    idle();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0010;
    @(negedge clk);
    vec++; if (dm_gnt !== 1'b1) begin miss++; $display("FAIL load_dm_gnt got %b want 1", dm_gnt); end
    vec++; if (if_gnt !== 1'b0) begin miss++; $display("FAIL load_if_gnt got %b want 0", if_gnt); end
    vec++; if (mem_address !== 8'h04) begin miss++; $display("FAIL load_addr got %h want 04", mem_address); end
    vec++; if (mem_w_en !== 1'b0) begin miss++; $display("FAIL load_w_en got %b want 0", mem_w_en); end
    tick();
    idle();
    vec++; if (dm_rvalid !== 1'b1) begin miss++; $display("FAIL load_rvalid got %b want 1", dm_rvalid); end
    vec++; if (if_rvalid !== 1'b0) begin miss++; $display("FAIL load_if_rvalid got %b want 0", if_rvalid); end
    vec++; if (dm_rdata !== 32'hC0DE_0004) begin miss++; $display("FAIL load_rdata got %h want c0de0004", dm_rdata); end
    tick();
  endtask

  task automatic test_store();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_be = 4'b0011; dm_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    vec++; if (mem_address !== 8'h08) begin miss++; $display("FAIL store_addr got %h want 08", mem_address); end
    vec++; if (mem_masking !== 4'b0011) begin miss++; $display("FAIL store_mask got %b want 0011", mem_masking); end
    vec++; if (mem_w_en !== 1'b1) begin miss++; $display("FAIL store_w_en got %b want 1", mem_w_en); end
    vec++; if (mem_write_data !== 32'hAABB_CCDD) begin miss++; $display("FAIL store_wdata got %h want aabbccdd", mem_write_data); end
    tick();
    idle();
    vec++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin miss++; $display("FAIL store_no_rvalid got %b want 00", {if_rvalid, dm_rvalid}); end
    dm_req = 1'b1; dm_addr = 32'h20;
    tick();
    idle();
    vec++; if (dm_rvalid !== 1'b1) begin miss++; $display("FAIL store_rb_rvalid got %b want 1", dm_rvalid); end
    vec++; if (dm_rdata !== 32'hC0DE_CCDD) begin miss++; $display("FAIL store_readback got %h want c0deccdd", dm_rdata); end
    tick();
  endtask

  task automatic test_conflict();
    logic exp_if, prev_if, prev_dm;
    prev_if = 1'b0; prev_dm = 1'b0;
    if_req = 1'b1; if_addr = 32'h0C; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h14;
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_RR_EN
      exp_if = ((i % 2) == 0);
`else
      exp_if = ((i % 5) == 4);
`endif
      @(negedge clk);
      vec++; if ({if_gnt, dm_gnt} !== {exp_if, ~exp_if}) begin miss++; $display("FAIL conflict_gnt[%0d] got %b want %b", i, {if_gnt, dm_gnt}, {exp_if, ~exp_if}); end
      vec++; if ({if_rvalid, dm_rvalid} !== {prev_if, prev_dm}) begin miss++; $display("FAIL conflict_rvalid[%0d] got %b want %b", i, {if_rvalid, dm_rvalid}, {prev_if, prev_dm}); end
      if (prev_if) begin
        vec++; if (if_rdata !== 32'hC0DE_0003) begin miss++; $display("FAIL conflict_if_rdata[%0d] got %h want c0de0003", i, if_rdata); end
      end
      if (prev_dm) begin
        vec++; if (dm_rdata !== 32'hC0DE_0005) begin miss++; $display("FAIL conflict_dm_rdata[%0d] got %h want c0de0005", i, dm_rdata); end
      end
      if (exp_if) begin
        vec++; if (mem_masking !== 4'b0000) begin miss++; $display("FAIL conflict_if_mask[%0d] got %b want 0000", i, mem_masking); end
      end
      prev_if = exp_if; prev_dm = ~exp_if;
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_alternate();
    if_req = 1'b1; if_addr = 32'h0;
    @(negedge clk);
    vec++; if ({if_gnt, dm_gnt} !== 2'b10) begin miss++; $display("FAIL alt_if_gnt got %b want 10", {if_gnt, dm_gnt}); end
    tick();
    idle();
    dm_req = 1'b1; dm_addr = 32'h4;
    @(negedge clk);
    vec++; if ({if_gnt, dm_gnt} !== 2'b01) begin miss++; $display("FAIL alt_dm_gnt got %b want 01", {if_gnt, dm_gnt}); end
    vec++; if ({if_rvalid, dm_rvalid} !== 2'b10) begin miss++; $display("FAIL alt_rvalid1 got %b want 10", {if_rvalid, dm_rvalid}); end
    vec++; if (if_rdata !== 32'hC0DE_0000) begin miss++; $display("FAIL alt_if_rdata got %h want c0de0000", if_rdata); end
    tick();
    idle();
    vec++; if ({if_rvalid, dm_rvalid} !== 2'b01) begin miss++; $display("FAIL alt_rvalid2 got %b want 01", {if_rvalid, dm_rvalid}); end
    vec++; if (dm_rdata !== 32'hC0DE_0001) begin miss++; $display("FAIL alt_dm_rdata got %h want c0de0001", dm_rdata); end
    tick();
  endtask

  task automatic test_wrap();
    if_req = 1'b1; if_addr = 32'h0000_0404;
    @(negedge clk);
    vec++; if (mem_address !== 8'h01) begin miss++; $display("FAIL wrap_addr got %h want 01", mem_address); end
    tick();
    idle();
    vec++; if (if_rdata !== 32'hC0DE_0001) begin miss++; $display("FAIL wrap_rdata got %h want c0de0001", if_rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    if_req = 1'b1; if_addr = 32'h8;
    tick();
    vec++; if (if_rvalid !== 1'b1) begin miss++; $display("FAIL mid_rvalid_pre got %b want 1", if_rvalid); end
    dm_req = 1'b1; dm_addr = 32'hC;
    #1 rst = 1'b1;
    #1;
    vec++; if (if_rvalid !== 1'b0) begin miss++; $display("FAIL mid_rvalid_drop got %b want 0", if_rvalid); end
    vec++; if ({if_gnt, dm_gnt, mem_request} !== 3'b000) begin miss++; $display("FAIL mid_gnt_in_rst got %b want 000", {if_gnt, dm_gnt, mem_request}); end
    tick();
    vec++; if ({if_rvalid, dm_rvalid} !== 2'b00) begin miss++; $display("FAIL mid_rvalid_hold got %b want 00", {if_rvalid, dm_rvalid}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
`ifdef ARB_RR_EN
    vec++; if ({if_gnt, dm_gnt} !== 2'b10) begin miss++; $display("FAIL mid_first_conflict got %b want 10", {if_gnt, dm_gnt}); end
`else
    vec++; if ({if_gnt, dm_gnt} !== 2'b01) begin miss++; $display("FAIL mid_first_conflict got %b want 01", {if_gnt, dm_gnt}); end
`endif
    tick();
    idle();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 32'hC0DE_0000 | 32'(i);
    mem_read_data = '0;
    idle();
    test_reset();
    test_load();
    test_store();
    test_conflict();
    test_alternate();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
